// File: rtl/mmio_debounce_pkg.sv
// Shared definitions for the debounce MMIO slot core: register indices
// and the debounce period register width.
// Latency: n/a (package). Backpressure: n/a.
package mmio_debounce_pkg;

  // Slot register indices, decoded from addr[2:0]
  localparam logic [2:0] REG_LEVEL  = 3'd0;
  localparam logic [2:0] REG_RISE   = 3'd1;
  localparam logic [2:0] REG_FALL   = 3'd2;
  localparam logic [2:0] REG_CLR    = 3'd3;
  localparam logic [2:0] REG_PERIOD = 3'd4;
  localparam logic [2:0] REG_MASK   = 3'd5;

  // Width of the debounce period register and of each per-bit counter
  localparam int PERIOD_W = 8;

endpackage

// File: rtl/mmio_debounce_core_bit.sv
// debounce_bit: 2-FF synchronizer plus tick-sampled debounce counter for one input.
// Latency: 2 clk for sync, then eff_period consecutive mismatching ticks; edge pulses coincide with the level update.
// Backpressure: none, free running.
// Ports: clk, reset (sync, active-high), tick (prescaler pulse), period (ticks, 0 acts as 1),
//        raw (async input), level (debounced), rise_p/fall_p (one-cycle combinational edge pulses).
module debounce_bit
  import mmio_debounce_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic [PERIOD_W-1:0] period,
  input  logic                raw,
  output logic                level,
  output logic                rise_p,
  output logic                fall_p
);

  logic                s_meta;
  logic                s_sync;
  logic                lvl;
  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] eff_period;
  logic [PERIOD_W:0]   cnt_inc;
  logic                diff;
  logic                done;
  logic                flip;

  assign eff_period = (period == '0) ? PERIOD_W'(1) : period;
  // One extra bit so cnt == 255 cannot wrap before the compare
  assign cnt_inc    = {1'b0, cnt} + (PERIOD_W+1)'(1);
  assign diff       = s_sync ^ lvl;
  assign done       = (cnt_inc >= {1'b0, eff_period});
  assign flip       = tick & diff & done;

  assign level  = lvl;
  assign rise_p = flip &  s_sync;
  assign fall_p = flip & ~s_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      s_meta <= 1'b0;
      s_sync <= 1'b0;
      lvl    <= 1'b0;
      cnt    <= '0;
    end else begin
      s_meta <= raw;
      s_sync <= s_meta;
      if (tick) begin
        if (diff) begin
          if (done) begin
            lvl <= s_sync;
            cnt <= '0;
          end else begin
            cnt <= cnt_inc[PERIOD_W-1:0];
          end
        end else begin
          // any agreeing sample restarts the count
          cnt <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/mmio_debounce_core.sv
// mmio_debounce_core: FPRO MMIO slot that debounces N_SW inputs and latches sticky edge events.
// Latency: rd_data combinational on addr; writes land on the cs&write edge; irq registered (1 clk after flag change).
// Backpressure: none; the slot always accepts reads and writes.
// Ports: clk, reset (sync, active-high), cs/read/write/addr/wr_data/rd_data (slot bus), din (raw inputs), irq.
// Optional: MMIO_DEBOUNCE_IRQ_EN adds the reg-5 event mask and a live irq (requires N_SW <= 16).
module mmio_debounce_core
  import mmio_debounce_pkg::*;
#(
  parameter int N_SW     = 10,
  parameter int TICK_DIV = 50000,
  parameter int DB_TICKS = 20
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cs,
  input  logic            read,
  input  logic            write,
  input  logic [4:0]      addr,
  input  logic [31:0]     wr_data,
  output logic [31:0]     rd_data,
  input  logic [N_SW-1:0] din,
  output logic            irq
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0]       presc;
  logic                tick;
  logic [2:0]          reg_sel;
  logic                wr_en;
  logic [N_SW-1:0]     clr_mask;
  logic [N_SW-1:0]     level;
  logic [N_SW-1:0]     rise_p;
  logic [N_SW-1:0]     fall_p;
  logic [N_SW-1:0]     rise_r;
  logic [N_SW-1:0]     fall_r;
  logic [PERIOD_W-1:0] period_r;
  logic                unused;

  // Reads have no side effects, and upper addr bits are don't-care
  assign unused = ^{read, addr[4:3], wr_data};

  assign reg_sel  = addr[2:0];
  assign wr_en    = cs & write;
  assign clr_mask = (wr_en && reg_sel == REG_CLR) ? wr_data[N_SW-1:0] : '0;
  assign tick     = (presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  for (genvar i = 0; i < N_SW; i++) begin : g_bit
    debounce_bit u_bit (
      .clk    (clk),
      .reset  (reset),
      .tick   (tick),
      .period (period_r),
      .raw    (din[i]),
      .level  (level[i]),
      .rise_p (rise_p[i]),
      .fall_p (fall_p[i])
    );
  end

  // Sticky flags: a pulse in the same cycle as a clear wins
  always_ff @(posedge clk) begin
    if (reset) begin
      rise_r   <= '0;
      fall_r   <= '0;
      period_r <= PERIOD_W'(DB_TICKS);
    end else begin
      rise_r <= (rise_r & ~clr_mask) | rise_p;
      fall_r <= (fall_r & ~clr_mask) | fall_p;
      if (wr_en && reg_sel == REG_PERIOD) begin
        period_r <= wr_data[PERIOD_W-1:0];
      end
    end
  end

`ifdef MMIO_DEBOUNCE_IRQ_EN
  logic [2*N_SW-1:0] mask_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_r <= '0;
      irq    <= 1'b0;
    end else begin
      if (wr_en && reg_sel == REG_MASK) begin
        mask_r <= wr_data[2*N_SW-1:0];
      end
      irq <= |((rise_r & mask_r[N_SW-1:0]) | (fall_r & mask_r[2*N_SW-1:N_SW]));
    end
  end
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_LEVEL:  rd_data[N_SW-1:0]     = level;
      REG_RISE:   rd_data[N_SW-1:0]     = rise_r;
      REG_FALL:   rd_data[N_SW-1:0]     = fall_r;
      REG_PERIOD: rd_data[PERIOD_W-1:0] = period_r;
`ifdef MMIO_DEBOUNCE_IRQ_EN
      REG_MASK:   rd_data[2*N_SW-1:0]   = mask_r;
`endif
      default:    rd_data = '0;
    endcase
  end

endmodule
